// File: rtl/vector_pkg.sv
// Shared types and constants for the vector memory sequencer.
// The stride port is only present when VMEM_STRIDE_EN is defined.
package vector_pkg;

    localparam int unsigned ELEM_W      = 32;
    localparam logic [31:0] UNIT_STRIDE = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } vmem_state_t;

endpackage

// File: rtl/vector_mem_sequencer_if.sv
// Element-level memory bus between the vector sequencer (master) and memory (slave).
interface vector_mem_sequencer_if;
    import vector_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [ELEM_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [ELEM_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/vmem_addr_gen.sv
// Element address register: loads base on start, then steps to base + (idx+1)*stride
// as each element completes. Arithmetic wraps modulo 2^32.
module vmem_addr_gen #(
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      base,
    input  logic [31:0]      stride,
    input  logic [IDX_W-1:0] idx,
    input  logic             load,
    input  logic             increment,
    output logic [31:0]      addr
);

    logic [31:0] base_q;
    logic [31:0] stride_q;
    logic [31:0] addr_q;
    logic [31:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = base;
        end else if (increment) begin
            addr_d = base_q + (32'(idx) + 32'd1) * stride_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            stride_q <= '0;
            addr_q   <= '0;
        end else begin
            if (load) begin
                base_q   <= base;
                stride_q <= stride;
            end
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Sequences a vector load/store as N single-element memory requests, stalling the front end.
// Define VMEM_STRIDE_EN to add the stride port; otherwise elements are unit-stride words.
module vector_mem_sequencer
    import vector_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [31:0]           base_addr,
`ifdef VMEM_STRIDE_EN
    input  logic [31:0]           stride,
`endif
    input  logic [N*ELEM_W-1:0]   store_data,
    vector_mem_sequencer_if.master mem,
    output logic                  stall,
    output logic [N*ELEM_W-1:0]   load_data,
    output logic                  load_valid,
    output logic                  busy
);

    localparam int unsigned     IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    vmem_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               is_store_q;
    logic [N*ELEM_W-1:0] sdata_q;
    logic [N*ELEM_W-1:0] ldata_q;
    logic [31:0]        stride_w;
    logic [31:0]        addr_w;
    logic               start_op;
    logic               elem_done;

`ifdef VMEM_STRIDE_EN
    assign stride_w = stride;
`else
    assign stride_w = UNIT_STRIDE;
`endif

    assign start_op  = (state_q == IDLE) && start;
    assign elem_done = (state_q == REQ) && mem.mem_ack;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    idx_d   = '0;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    if (idx_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            is_store_q <= 1'b0;
            sdata_q    <= '0;
            ldata_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (start_op) begin
                is_store_q <= is_store;
                sdata_q    <= store_data;
            end
            if (elem_done && !is_store_q) begin
                ldata_q[idx_q*ELEM_W +: ELEM_W] <= mem.mem_rdata;
            end
        end
    end

    // Address is registered so it is stable for the whole request, however long ack takes.
    vmem_addr_gen #(
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .base      (base_addr),
        .stride    (stride_w),
        .idx       (idx_q),
        .load      (start_op),
        .increment (elem_done && (idx_q != LAST)),
        .addr      (addr_w)
    );

    assign mem.mem_req   = (state_q == REQ);
    assign mem.mem_we    = is_store_q;
    assign mem.mem_addr  = addr_w;
    assign mem.mem_wdata = sdata_q[idx_q*ELEM_W +: ELEM_W];

    assign stall      = (state_q == REQ) || start_op;
    assign busy       = (state_q != IDLE);
    assign load_valid = (state_q == DONE) && !is_store_q;
    assign load_data  = ldata_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench: behavioural element-sequence model plus directed and random operations.
module tb_vector_mem_sequencer;
    import vector_pkg::*;

    localparam int unsigned N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            is_store = 1'b0;
    logic [31:0]     base_addr = '0;
`ifdef VMEM_STRIDE_EN
    logic [31:0]     stride = 32'd4;
`endif
    logic [N*32-1:0] store_data = '0;
    logic            stall;
    logic [N*32-1:0] load_data;
    logic            load_valid;
    logic            busy;

    vector_mem_sequencer_if mem();

    vector_mem_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .base_addr  (base_addr),
`ifdef VMEM_STRIDE_EN
        .stride     (stride),
`endif
        .store_data (store_data),
        .mem        (mem),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_active, m_done, m_we;
    int unsigned m_elem;
    logic [31:0] m_base, m_stride;
    logic [31:0] m_sd [N];
    logic [31:0] m_ld [N];

    int unsigned cyc = 0, op_start_cyc = 0, lv_cyc = 0, end_cyc = 0, ops_started = 0, hold_cur = 0;
    bit          lv_seen = 0;
    logic [31:0] acc_q [$];
    int unsigned hold_q [$];

    function automatic logic [N*32-1:0] pack_ld();
        logic [N*32-1:0] r;
        for (int i = 0; i < N; i++) r[i*32 +: 32] = m_ld[i];
        return r;
    endfunction

    always @(negedge clk) begin
        logic [31:0] exp_addr;
        cyc++;
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_we = 0; m_elem = 0;
            m_base = '0; m_stride = '0; hold_cur = 0;
            for (int i = 0; i < N; i++) begin m_sd[i] = '0; m_ld[i] = '0; end
            chk("rst_addr", mem.mem_addr, '0);
            chk("rst_wdata", mem.mem_wdata, '0);
        end
        chk("mem_req", mem.mem_req, m_active);
        chk("mem_we", mem.mem_we, m_we);
        if (m_active) begin
            exp_addr = m_base + m_elem * m_stride;
            chk("mem_addr", mem.mem_addr, exp_addr);
            chk("mem_wdata", mem.mem_wdata, m_sd[m_elem]);
        end
        chk("stall", stall, m_active || (!m_active && !m_done && start));
        chk("busy", busy, m_active || m_done);
        chk("load_valid", load_valid, m_done && !m_we);
        chk("load_data", load_data, pack_ld());
        if (load_valid) begin lv_cyc = cyc; lv_seen = 1; end

        if (rst_n) begin
            if (m_active) begin
                hold_cur++;
                if (mem.mem_ack) begin
                    acc_q.push_back(mem.mem_addr);
                    hold_q.push_back(hold_cur);
                    hold_cur = 0;
                    if (!m_we) m_ld[m_elem] = mem.mem_rdata;
                    if (m_elem == N - 1) begin m_active = 0; m_done = 1; end
                    else m_elem++;
                end
            end else if (m_done) begin
                m_done  = 0;
                end_cyc = cyc + 1;
            end else if (start) begin
                m_active = 1; m_elem = 0; m_base = base_addr; m_we = is_store;
`ifdef VMEM_STRIDE_EN
                m_stride = stride;
`else
                m_stride = 32'd4;
`endif
                for (int i = 0; i < N; i++) m_sd[i] = store_data[i*32 +: 32];
                op_start_cyc = cyc;
                ops_started++;
            end
        end
    end

    // ---------------- memory responder ----------------
    int ack_delay = 0;       // negative: random 0..3 per element
    bit rdata_is_addr = 1;
    bit spurious = 0;

    initial begin
        int cnt = 0, cur_delay = 0;
        bit prev_req = 0, prev_ack = 0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (prev_req && !prev_ack) cnt++;
            else begin
                cnt = 0;
                cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            end
            if (mem.mem_req) mem.mem_ack = (cnt >= cur_delay);
            else mem.mem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem.mem_rdata = rdata_is_addr ? mem.mem_addr : $urandom;
            prev_req = mem.mem_req;
            prev_ack = mem.mem_ack;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while (busy && n < limit) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic run_op(input bit st, input logic [31:0] base, input logic [N*32-1:0] sd);
        is_store = st; base_addr = base; store_data = sd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(200);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        hold_q.delete();
    endtask

    initial begin
        logic [N*32-1:0] sd;
        int unsigned n, ops0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_req", mem.mem_req, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ld", load_data, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero-wait load, rdata mirrors address
        clear_logs();
        run_op(1'b0, 32'h100, '0);
        chk("t041_count", acc_q.size(), 4);
        chk("t041_a0", acc_q[0], 32'h100);
        chk("t041_a1", acc_q[1], 32'h104);
        chk("t041_a2", acc_q[2], 32'h108);
        chk("t041_a3", acc_q[3], 32'h10C);
        chk("t041_lv_cycle", lv_cyc - op_start_cyc, 5);
        chk("t041_op_len", end_cyc - op_start_cyc, N + 2);
        chk("t041_ld", load_data, {32'h10C, 32'h108, 32'h104, 32'h100});

        // Store with each ack two cycles late; load_data must survive
        ack_delay = 2;
        clear_logs();
        run_op(1'b1, 32'h40, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
        chk("t042_count", acc_q.size(), 4);
        for (int i = 0; i < 4; i++) chk("t042_hold", hold_q[i], 3);
        chk("t042_ld_kept", load_data, {32'h10C, 32'h108, 32'h104, 32'h100});

        // start held high through REQ: still one operation
        ack_delay = 0;
        clear_logs();
        ops0 = ops_started;
        is_store = 1'b0; base_addr = 32'h200; start = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_idle(200);
        @(posedge clk); #1;
        chk("t043_reqs", acc_q.size(), 4);
        chk("t043_ops", ops_started - ops0, 1);

        // Address wrap-around
        clear_logs();
        run_op(1'b0, 32'hFFFF_FFF8, '0);
        chk("t044_a0", acc_q[0], 32'hFFFF_FFF8);
        chk("t044_a1", acc_q[1], 32'hFFFF_FFFC);
        chk("t044_a2", acc_q[2], 32'h0000_0000);
        chk("t044_a3", acc_q[3], 32'h0000_0004);

        // Reset while element 2 is outstanding
        ack_delay = 1;
        is_store = 1'b0; base_addr = 32'h300; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(m_active && m_elem == 2) && n < 50) begin @(posedge clk); #1; n++; end
        chk("t045_reached_elem2", m_active && m_elem == 2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t045_req_drop", mem.mem_req, 1'b0);
        chk("t045_busy_drop", busy, 1'b0);
        lv_seen = 0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("t045_busy_after", busy, 1'b0);
        chk("t045_no_lv", lv_seen, 1'b0);

`ifdef VMEM_STRIDE_EN
        ack_delay = 0;
        clear_logs();
        stride = 32'd16;
        run_op(1'b0, 32'h0, '0);
        chk("t046_a0", acc_q[0], 32'd0);
        chk("t046_a1", acc_q[1], 32'd16);
        chk("t046_a2", acc_q[2], 32'd32);
        chk("t046_a3", acc_q[3], 32'd48);
`endif

        // Random operations: random waits, spurious acks, start held or re-driven mid-op
        ack_delay = -1;
        spurious = 1;
        rdata_is_addr = 0;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) sd[i*32 +: 32] = $urandom;
            is_store = 1'($urandom_range(0, 1));
            base_addr = $urandom;
            store_data = sd;
`ifdef VMEM_STRIDE_EN
            stride = $urandom;
`endif
            start = 1'b1;
            n = $urandom_range(1, 6);
            repeat (n) begin
                @(posedge clk); #1;
                base_addr = $urandom;
                is_store = 1'($urandom_range(0, 1));
            end
            start = 1'b0;
            wait_idle(200);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end

        repeat (2) begin @(posedge clk); #1; end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
